// File: rtl/button_gesture_if.sv
// Button gesture bus: debounced press/release pulses in, gesture pulses and
// last-gesture code out. `release` and `repeat` are reserved words, hence
// release_pulse / repeat_pulse.
interface button_gesture_if;
    logic       press;
    logic       release_pulse;
    logic       short_press;
    logic       long_press;
    logic       repeat_pulse;
    logic       double_press;
    logic       held;
    logic [1:0] last_code;

    // Debouncer / stimulus side
    modport master (
        output press, release_pulse,
        input  short_press, long_press, repeat_pulse, double_press, held, last_code
    );

    // Gesture classifier side
    modport slave (
        input  press, release_pulse,
        output short_press, long_press, repeat_pulse, double_press, held, last_code
    );
endinterface

// File: rtl/button_gesture.sv
// Push-button gesture classifier: short press, long press with auto-repeat,
// double press. Timing runs off a ms tick from a cycle prescaler; both
// counters restart on every state change so each interval is exact.
module button_gesture #(
    parameter int TICK_CYCLES = 12000,
    parameter int LONG_MS     = 800,
    parameter int DOUBLE_MS   = 300,
    parameter int REPEAT_MS   = 150
) (
    input  logic              CLK,
    input  logic              RST_N,
    button_gesture_if.slave   bus
);

    localparam logic [1:0] CODE_SHORT  = 2'd1;
    localparam logic [1:0] CODE_LONG   = 2'd2;
    localparam logic [1:0] CODE_DOUBLE = 2'd3;

    typedef enum logic [2:0] {IDLE, PRESS1, LONG, WAIT2, PRESS2} state_t;

    state_t      state;
    logic [15:0] presc;
    logic [9:0]  ms;

    logic        short_q, long_q, repeat_q, double_q, held_q;
    logic [1:0]  code_q;

    logic        tick, press_evt, release_evt;
    logic        long_due, double_due, repeat_due;

    // Event decode; an interval expires on the tick that would bring the ms
    // count up to its limit, so the registered pulse lands exactly on time.
    always_comb begin
        tick        = (presc == 16'(TICK_CYCLES - 1));
        press_evt   = bus.press & ~bus.release_pulse;
        release_evt = bus.release_pulse & ~bus.press;
        long_due    = tick && (ms == 10'(LONG_MS - 1));
        double_due  = tick && (ms == 10'(DOUBLE_MS - 1));
        repeat_due  = tick && (ms == 10'(REPEAT_MS - 1));
    end

    // Gesture FSM with timers and registered outputs; a later counter clear
    // in a branch overrides the default advance.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            presc    <= '0;
            ms       <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            double_q <= 1'b0;
            held_q   <= 1'b0;
            code_q   <= '0;
        end else begin
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            double_q <= 1'b0;

            if (tick) begin
                presc <= '0;
                ms    <= ms + 10'd1;
            end else begin
                presc <= presc + 16'd1;
            end

            case (state)
                IDLE: begin
                    presc <= '0;
                    ms    <= '0;
                    if (press_evt) begin
                        state  <= PRESS1;
                        held_q <= 1'b1;
                    end
                end
                PRESS1: begin
                    // Release beats a coincident long-press expiry
                    if (release_evt) begin
                        state  <= WAIT2;
                        held_q <= 1'b0;
                        presc  <= '0;
                        ms     <= '0;
                    end else if (long_due) begin
                        state  <= LONG;
                        long_q <= 1'b1;
                        code_q <= CODE_LONG;
                        presc  <= '0;
                        ms     <= '0;
                    end
                end
                LONG: begin
                    if (release_evt) begin
                        state  <= IDLE;
                        held_q <= 1'b0;
                        presc  <= '0;
                        ms     <= '0;
                    end else if (repeat_due) begin
                        repeat_q <= 1'b1;
                        presc    <= '0;
                        ms       <= '0;
                    end
                end
                WAIT2: begin
                    // Second press beats a coincident double-window expiry
                    if (press_evt) begin
                        state    <= PRESS2;
                        held_q   <= 1'b1;
                        double_q <= 1'b1;
                        code_q   <= CODE_DOUBLE;
                        presc    <= '0;
                        ms       <= '0;
                    end else if (double_due) begin
                        state   <= IDLE;
                        short_q <= 1'b1;
                        code_q  <= CODE_SHORT;
                        presc   <= '0;
                        ms      <= '0;
                    end
                end
                PRESS2: begin
                    if (release_evt) begin
                        state  <= IDLE;
                        held_q <= 1'b0;
                        presc  <= '0;
                        ms     <= '0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    held_q <= 1'b0;
                    presc  <= '0;
                    ms     <= '0;
                end
            endcase
        end
    end

    assign bus.short_press  = short_q;
    assign bus.long_press   = long_q;
    assign bus.repeat_pulse = repeat_q;
    assign bus.double_press = double_q;
    assign bus.held         = held_q;
    assign bus.last_code    = code_q;

endmodule
